// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state encoding and helpers for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per cycle after start.
module hilo_div_core
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic        run_q;
  logic [4:0]  cnt_q;
  logic [63:0] rq_q;
  logic [31:0] dvsr_q;

  logic [32:0] partial_s;
  logic [33:0] diff_s;
  logic [63:0] step_s;

  // Partial remainder needs 33 bits: divisors above 2^31 can make rem*2 overflow 32 bits.
  always_comb begin
    partial_s = rq_q[63:31];
    diff_s    = {1'b0, partial_s} - {2'b00, dvsr_q};
    if (diff_s[33]) begin
      step_s = {partial_s[31:0], rq_q[30:0], 1'b0};
    end else begin
      step_s = {diff_s[31:0], rq_q[30:0], 1'b1};
    end
  end

  // Step sequencer and {rem,quot} shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= 5'd0;
      rq_q   <= 64'd0;
      dvsr_q <= 32'd0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= 5'd0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= 5'd0;
      rq_q   <= {32'd0, dividend_i};
      dvsr_q <= divisor_i;
    end else if (run_q) begin
      rq_q  <= step_s;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_STEPS - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q && (cnt_q == 5'(DIV_STEPS - 1));
  assign quot_o = rq_q[31:0];
  assign rem_o  = rq_q[63:32];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage HI/LO owner: sequences multiply/divide, raises stall, commits results and
// exposes the write port used by ID-stage HILO forwarding.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall_req,
  output logic        busy,
  output logic [63:0] hilo_o,
  output logic [1:0]  hilo_we,
  output logic [63:0] hilo_wdata
);

  localparam int unsigned MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e          state_q;
  logic            busy_q;
  logic [63:0]     hilo_q;
  logic [MCW-1:0]  mul_cnt_q;
  logic [31:0]     mul_a_q, mul_b_q;
  logic            mul_sgn_q;
  logic [63:0]     res_q;
  logic            res_div_q, neg_quot_q, neg_rem_q;

  logic        is_mul_s, is_div_s, accept_s, div_start_s, div_done_s;
  logic [31:0] div_a_s, div_b_s, quot_s, rem_s, quot_fix_s, rem_fix_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s, done_data_s;

  // Operand decode, product and signed-divide fixups.
  always_comb begin
    is_mul_s    = (op == OP_MULT) || (op == OP_MULTU);
    is_div_s    = (op == OP_DIV) || (op == OP_DIVU);
    accept_s    = !rst && !flush && op_valid && (state_q == ST_IDLE);
    div_start_s = accept_s && is_div_s && (rt_data != 32'd0);
    div_a_s     = (op == OP_DIV) ? abs32(rs_data) : rs_data;
    div_b_s     = (op == OP_DIV) ? abs32(rt_data) : rt_data;
    ext_a_s     = mul_sgn_q ? {{32{mul_a_q[31]}}, mul_a_q} : {32'd0, mul_a_q};
    ext_b_s     = mul_sgn_q ? {{32{mul_b_q[31]}}, mul_b_q} : {32'd0, mul_b_q};
    prod_s      = ext_a_s * ext_b_s;
    quot_fix_s  = neg_quot_q ? (32'd0 - quot_s) : quot_s;
    rem_fix_s   = neg_rem_q ? (32'd0 - rem_s) : rem_s;
    done_data_s = res_div_q ? {rem_fix_s, quot_fix_s} : res_q;
  end

  // Stall request and HILO write port; flush and reset silence both.
  always_comb begin
    stall_req  = 1'b0;
    hilo_we    = 2'b00;
    hilo_wdata = 64'd0;
    if (!rst && !flush) begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: stall_req = 1'b1;
              OP_MTHI: begin
                hilo_we    = 2'b10;
                hilo_wdata = {rs_data, hilo_q[31:0]};
              end
              OP_MTLO: begin
                hilo_we    = 2'b01;
                hilo_wdata = {hilo_q[63:32], rs_data};
              end
              default: stall_req = 1'b0;
            endcase
          end else begin
            stall_req = 1'b0;
          end
        end
        ST_MUL, ST_DIV: stall_req = 1'b1;
        ST_DONE: begin
          hilo_we    = 2'b11;
          hilo_wdata = done_data_s;
        end
        default: stall_req = 1'b0;
      endcase
    end else begin
      stall_req = 1'b0;
      hilo_we   = 2'b00;
    end
  end

  // Sequencer FSM, HI/LO architectural state and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      hilo_q     <= 64'd0;
      mul_cnt_q  <= '0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      mul_sgn_q  <= 1'b0;
      res_q      <= 64'd0;
      res_div_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      if (hilo_we[1]) hilo_q[63:32] <= hilo_wdata[63:32];
      if (hilo_we[0]) hilo_q[31:0]  <= hilo_wdata[31:0];
      if (flush) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        mul_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (op_valid && is_mul_s) begin
              mul_a_q   <= rs_data;
              mul_b_q   <= rt_data;
              mul_sgn_q <= (op == OP_MULT);
              mul_cnt_q <= '0;
              state_q   <= ST_MUL;
              busy_q    <= 1'b1;
            end else if (op_valid && is_div_s) begin
              // Divide-by-zero bypasses the core and commits {rs, all-ones}.
              res_q      <= {rs_data, 32'hFFFF_FFFF};
              res_div_q  <= (rt_data != 32'd0);
              neg_quot_q <= (op == OP_DIV) && (rs_data[31] ^ rt_data[31]);
              neg_rem_q  <= (op == OP_DIV) && rs_data[31];
              state_q    <= (rt_data == 32'd0) ? ST_DONE : ST_DIV;
              busy_q     <= 1'b1;
            end
          end
          ST_MUL: begin
            if (mul_cnt_q == MCW'(MUL_CYCLES - 1)) begin
              res_q     <= prod_s;
              res_div_q <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              mul_cnt_q <= mul_cnt_q + 1'b1;
            end
          end
          ST_DIV: begin
            if (div_done_s) state_q <= ST_DONE;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  hilo_div_core u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_s),
    .abort_i    (flush),
    .dividend_i (div_a_s),
    .divisor_i  (div_b_s),
    .done_o     (div_done_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s)
  );

  assign busy   = busy_q;
  assign hilo_o = hilo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed ops push expected writes, a monitor checks them.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        stall_req, busy;
  logic [63:0] hilo_o, hilo_wdata;
  logic [1:0]  hilo_we;

  int checks = 0;
  int errors = 0;
  int stall_run = 0;

  typedef struct {
    logic [1:0]  we;
    logic [63:0] wdata;
    int          stall;
  } exp_t;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] mon_mask;

  hilo_muldiv_ctrl #(.MUL_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .flush      (flush),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .stall_req  (stall_req),
    .busy       (busy),
    .hilo_o     (hilo_o),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every HILO write must match the oldest expected write; also measures stall length.
  always @(negedge clk) begin
    if (hilo_we != 2'b00) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual we=%b wdata=%h expected no write", hilo_we, hilo_wdata);
      end else begin
        mon_e    = sb_q.pop_front();
        mon_mask = {{32{mon_e.we[1]}}, {32{mon_e.we[0]}}};
        check64("write_we", {62'd0, hilo_we}, {62'd0, mon_e.we});
        check64("write_data", hilo_wdata & mon_mask, mon_e.wdata & mon_mask);
        check64("stall_len", 64'(stall_run), 64'(mon_e.stall));
      end
    end
    if (stall_req) stall_run++;
    else stall_run = 0;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] we, input logic [63:0] wd, input int stall);
    exp_t e;
    e.we = we; e.wdata = wd; e.stall = stall;
    if (we != 2'b00) sb_q.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!done) begin
        @(negedge clk);
        if (!busy) done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual busy=1 expected busy=0 within 100 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int stall);
    issue(o, a, b, 2'b11, exp, stall);
    wait_idle(name);
    check64(name, hilo_o, exp);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = OP_NONE;
    rs_data = 32'd0; rt_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check64("reset_hilo", hilo_o, 64'd0);
    check64("reset_busy", {63'd0, busy}, 64'd0);
    check64("reset_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mult_neg1x2",   OP_MULT,  32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("multu_max_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 3);
    run_op("mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3);
    run_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("divu_7_2",      OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 33);
    run_op("div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
    run_op("div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
    run_op("divu_big_dvsr", OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001, 33);
    run_op("div_by_zero",   OP_DIV,   32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1);

    // MTHI then MTLO back to back: no stall, both halves visible two cycles later.
    sb_q.push_back('{we: 2'b10, wdata: {32'h1234_5678, 32'd0}, stall: 0});
    sb_q.push_back('{we: 2'b01, wdata: {32'd0, 32'h9ABC_DEF0}, stall: 0});
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MTHI; rs_data = 32'h1234_5678;
    @(posedge clk); #1;
    op = OP_MTLO; rs_data = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    check64("mthi_mtlo", hilo_o, 64'h1234_5678_9ABC_DEF0);
    check64("mthi_mtlo_busy", {63'd0, busy}, 64'd0);

    // Flush ten cycles into a divide: no write, HI/LO kept, idle right after.
    issue(OP_DIVU, 32'd100, 32'd7, 2'b00, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check64("flush_stall", {63'd0, stall_req}, 64'd0);
    check64("flush_we", {62'd0, hilo_we}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check64("flush_busy", {63'd0, busy}, 64'd0);
    check64("flush_hilo", hilo_o, 64'h1234_5678_9ABC_DEF0);

    run_op("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33);

    // Reset in the middle of a divide.
    issue(OP_DIV, 32'd1000, 32'd3, 2'b00, 64'd0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check64("rst_div_stall", {63'd0, stall_req}, 64'd0);
    check64("rst_div_we", {62'd0, hilo_we}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check64("rst_div_hilo", hilo_o, 64'd0);
    check64("rst_div_busy", {63'd0, busy}, 64'd0);
    check64("rst_div_stall_after", {63'd0, stall_req}, 64'd0);

    run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 3);

    repeat (3) @(posedge clk);
    check64("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a fixed-latency multiply or a 32-step radix-2 restoring divide. It raises a pipeline stall request for the duration, then commits the 64-bit result to HI/LO. It also drives the HILO write-port signals that the ID-stage HILO forwarding logic consumes.

## Interface
Parameters:
- MUL_CYCLES, default 2: number of cycles the MUL state lasts (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  EX holds a HILO-class instruction this cycle.
- op  in  3  operation code (hilo_pkg encoding).
- flush  in  1  EX instruction is squashed this cycle.
- rs_data  in  32  dividend / multiplicand / MTHI-MTLO source.
- rt_data  in  32  divisor / multiplier.
- stall_req  out  1  freeze IF..EX; combinational.
- busy  out  1  FSM not in IDLE; registered.
- hilo_o  out  64  current {HI,LO}; registered.
- hilo_we  out  2  HILO write enables this cycle: bit1 HI, bit0 LO.
- hilo_wdata  out  64  {HI,LO} data being written this cycle.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and 0 are treated as NONE.
- States:
  - IDLE
  - MUL: counter runs MUL_CYCLES cycles.
  - DIV: 32 iterations, one quotient bit per cycle.
  - DONE: write-back cycle.
- IDLE, with op_valid and !flush:
  - MULT/MULTU: latch operands, go to MUL.
  - DIV/DIVU with rt_data≠0: latch |rs| and |rt| (raw values for DIVU) and the sign flags, go to DIV.
  - DIV/DIVU with rt_data=0: go directly to DONE. Result is HI=rs_data, LO=32'hFFFFFFFF.
  - MTHI: hilo_we=2'b10 and hilo_wdata[63:32]=rs_data in the same cycle. HI updates at the cycle end. No stall, stay in IDLE.
  - MTLO: same as MTHI, but hilo_we=2'b01 and the LO half.
- MUL: 64-bit product, signed for MULT and unsigned for MULTU. The product is registered at the end of the last MUL cycle, then the FSM goes to DONE.
- DIV: restoring step on a 64-bit {rem,quot} shift register. After 32 steps the FSM goes to DONE.
- Signed-divide fixups, applied at DONE:
  - quotient is negated if the operand signs differ;
  - remainder takes the dividend's sign.
- DONE: hilo_we=2'b11, hilo_wdata={remainder,quotient} for divides or {prod_hi,prod_lo} for multiplies. hilo_o takes that value at the cycle end. The FSM returns to IDLE unconditionally and ignores op_valid this cycle.
- flush has priority over everything in every state. FSM goes to IDLE, no HILO write, hilo_we=0 that cycle.
- stall_req = (state==IDLE && op_valid && !flush && op∈{MULT,MULTU,DIV,DIVU}) || state∈{MUL,DIV}. It is low in DONE, so the instruction advances exactly as the result commits.
- rst: state=IDLE, hilo_o=0, busy=0, counters=0. hilo_we=0 and stall_req=0 in the reset cycle.

## Timing
- Accept cycle T has stall_req=1.
- Multiply:
  - MUL occupies T+1..T+MUL_CYCLES;
  - DONE is at T+MUL_CYCLES+1;
  - hilo_o is valid from T+MUL_CYCLES+2;
  - total stall is MUL_CYCLES+1 cycles.
- Divide:
  - DIV occupies T+1..T+32;
  - DONE is at T+33;
  - total stall is 33 cycles.
- Divide by zero: DONE at T+1, stall of 1 cycle.
- MTHI/MTLO: 0 stall; hilo_o updates at T+1.
- Back-to-back: a new op can be accepted in the cycle after DONE, never in DONE itself.
- A flush in the same cycle as DONE suppresses the write.

## Structure
- Package hilo_pkg:
  - op code localparams;
  - state enum (IDLE, MUL, DIV, DONE);
  - DIV_STEPS=32.
- Sub-module hilo_div_core holds the iterative unsigned restoring divider.
  - Interface: start, operands, done, quotient, remainder.
  - This block owns the sign handling, the FSM and HILO.
- The multiplier is inferred inline, with a MUL_CYCLES-deep counter gating capture.

## Test plan
- MULT rs=32'hFFFFFFFF, rt=2 → stall for 3 cycles (MUL_CYCLES=2), hilo_we=2'b11 in DONE, hilo_o={32'hFFFFFFFF,32'hFFFFFFFE}.
- MULTU with the same operands → hilo_o={32'h00000001,32'hFFFFFFFE}.
- DIV rs=-7, rt=2 → 33 stall cycles, hilo_o={32'hFFFFFFFF,32'hFFFFFFFD}.
- DIVU rs=7, rt=2 → hilo_o={1,3}.
- DIV with rt=0, rs=5 → 1 stall cycle, hilo_o={5,32'hFFFFFFFF}.
- DIVU started, flush at T+10 → stall_req=0 from T+10, hilo_o unchanged, busy=0 at T+11.
- MTHI 32'h12345678 then MTLO 32'h9ABCDEF0 in consecutive cycles → no stall, hilo_o={32'h12345678,32'h9ABCDEF0} at T+2.
- rst asserted during DIV → IDLE next cycle, hilo_o=0, stall_req=0.
